seq_det_param: RTL and testbench

Parametrised serial bit-pattern detector, the next generation of the team's fixed-pattern Mealy detector (hard-wired 00110). Pattern, pattern length and overlap mode are runtime-programmable up to MAX_LEN bits, and input is qualified by a valid strobe. The block sits on a serial data path and drives a registered one-cycle match pulse to downstream control logic.

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/seq_det_cmp.sv | 25 ++
 rtl/seq_det_param.sv | 139 +++++++++++++
 tb/tb_seq_det_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types, constants and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        SEQ_NONOVERLAP = 1'b0,
        SEQ_OVERLAP    = 1'b1
    } ovl_mode_e;

    // Pattern and length that are active straight out of reset (the legacy 00110 detector)
    localparam logic [31:0] RST_PATTERN = 32'b00110;
    localparam int          RST_LEN     = 5;

    // A programmed length is usable only if it is non-zero and fits the history register
    function automatic logic len_ok(input int len, input int max);
        return (len != 0) && (len <= max);
    endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// Masked comparison of the shift history against the active pattern over the low len bits.
module seq_det_cmp
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic [MAX_LEN-1:0] hist,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
    output logic               hit_raw
);

    logic [MAX_LEN-1:0] mask;

    // Build a mask covering bits 0..len-1 and compare only those bits
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
        hit_raw = (((hist ^ pat) & mask) == '0);
    end

endmodule

// File: rtl/seq_det_param.sv
// Runtime-programmable serial bit-pattern detector with a registered one-cycle match pulse.
// Optional build macro SEQ_DET_CNT_EN adds a saturating match counter and the match_cnt port.
module seq_det_param
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN) + 1,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(seq_det_pkg::RST_PATTERN),
    parameter int                 RST_LEN     = seq_det_pkg::RST_LEN,
    parameter bit                 RST_OVERLAP = 1'b0,
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               match,
    output logic               cfg_err
`ifdef SEQ_DET_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt
`endif
);

    import seq_det_pkg::*;

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    ovl_mode_e          ovl_q, ovl_d;
    logic               match_q, match_d;
    logic               cfg_err_q, cfg_err_d;

    logic               accept;
    logic               hit_raw;
    logic               hit;
    logic               fill_full;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W:0]     fill_inc;

    // A load cycle consumes the strobe, so the serial bit is dropped that cycle
    assign accept     = in_valid & ~cfg_load;
    assign hist_shift = {hist_q[MAX_LEN-2:0], in_bit};
    assign fill_inc   = {1'b0, fill_q} + (LEN_W + 1)'(1);
    assign fill_full  = (fill_inc >= {1'b0, len_q});
    assign hit        = accept & ~cfg_err_q & fill_full & hit_raw;

    seq_det_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .hist    (hist_shift),
        .pat     (pat_q),
        .len     (len_q),
        .hit_raw (hit_raw)
    );

    // Next-state: configuration load has priority over accepting a serial bit
    always_comb begin
        hist_d    = hist_q;
        pat_d     = pat_q;
        len_d     = len_q;
        fill_d    = fill_q;
        ovl_d     = ovl_q;
        cfg_err_d = cfg_err_q;
        match_d   = 1'b0;
        if (cfg_load) begin
            pat_d     = cfg_pattern;
            len_d     = cfg_len;
            ovl_d     = ovl_mode_e'(cfg_overlap);
            hist_d    = '0;
            fill_d    = '0;
            cfg_err_d = ~len_ok(int'(cfg_len), MAX_LEN);
        end else if (accept) begin
            hist_d = hist_shift;
            fill_d = fill_full ? len_q : fill_inc[LEN_W-1:0];
            if (hit) begin
                match_d = 1'b1;
                if (ovl_q == SEQ_NONOVERLAP) begin
                    fill_d = '0;
                end
            end
        end
    end

    // State registers, cleared to the legacy-compatible configuration on reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_q    <= '0;
            pat_q     <= RST_PATTERN;
            len_q     <= LEN_W'(RST_LEN);
            fill_q    <= '0;
            ovl_q     <= ovl_mode_e'(RST_OVERLAP);
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            fill_q    <= fill_d;
            ovl_q     <= ovl_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match   = match_q;
    assign cfg_err = cfg_err_q;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count hits, holding at the top value and restarting on every configuration load
    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Match counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: stimulus pushes expected responses, a monitor pops and compares.
module tb_seq_det_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;
    localparam int CNT_W   = 2;

    typedef struct {
        logic  expMatch;
        logic  expErr;
        int    expCnt;
        string name;
    } exp_t;

    logic               clk = 1'b0;
    logic               rstn;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in_bit;
    logic               match;
    logic               cfg_err;
`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0]   match_cnt;
`endif

    exp_t scoreQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    seq_det_param #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .match       (match),
        .cfg_err     (cfg_err)
`ifdef SEQ_DET_CNT_EN
        ,
        .match_cnt   (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Single comparison point shared by the monitor and the direct reset checks
    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    // Compare one popped scoreboard entry against the current DUT outputs
    task automatic checkOutput(input exp_t e);
        checkValue({e.name, " match"}, 32'(match), 32'(e.expMatch));
        checkValue({e.name, " cfg_err"}, 32'(cfg_err), 32'(e.expErr));
`ifdef SEQ_DET_CNT_EN
        if (e.expCnt >= 0) begin
            checkValue({e.name, " match_cnt"}, 32'(match_cnt), 32'(e.expCnt));
        end
`endif
    endtask

    // Monitor: sample just after each active edge and consume one expectation per driven cycle
    always @(posedge clk) begin
        #1;
        if (scoreQ.size() > 0) begin
            checkOutput(scoreQ.pop_front());
        end
    end

    // Drive one cycle of inputs and record what the DUT must show after the sampling edge
    task automatic applyStimulus(input logic load, input logic valid, input logic bitIn,
                                 input logic expMatch, input logic expErr, input int expCnt,
                                 input string name);
        exp_t e;
        @(negedge clk);
        cfg_load = load;
        in_valid = valid;
        in_bit   = bitIn;
        e.expMatch = expMatch;
        e.expErr   = expErr;
        e.expCnt   = expCnt;
        e.name     = name;
        scoreQ.push_back(e);
    endtask

    task automatic loadCfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic ovl, input logic valid, input logic bitIn,
                           input logic expErr, input string name);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        applyStimulus(1'b1, valid, bitIn, 1'b0, expErr, 0, name);
    endtask

    // Stream n bits, bits[n-1] first; expM holds the expected match bit per sent bit
    task automatic sendBits(input logic [63:0] bits, input logic [63:0] expM, input int n,
                            input logic expErr, input string name);
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b1, bits[i], expM[i], expErr, -1, name);
        end
    endtask

    task automatic idleCycles(input int n, input logic expErr, input string name);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, expErr, -1, name);
        end
    endtask

    // Watchdog so a stuck run still terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    // Directed test sequence
    initial begin
        int drain;
        rstn        = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        in_valid    = 1'b0;
        in_bit      = 1'b0;
        repeat (2) @(negedge clk);
        checkValue("reset match", 32'(match), 32'd0);
        checkValue("reset cfg_err", 32'(cfg_err), 32'd0);
`ifdef SEQ_DET_CNT_EN
        checkValue("reset match_cnt", 32'(match_cnt), 32'd0);
`endif
        rstn = 1'b1;

        // Default pattern 00110 is live right after reset, non-overlapping
        sendBits(64'b00110,  64'b00001,  5, 1'b0, "dflt first");
        sendBits(64'b100110, 64'b000001, 6, 1'b0, "dflt second");

        // Pattern 101, overlapping then non-overlapping
        loadCfg(8'b101, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, "load 101 ovl");
        sendBits(64'b10101, 64'b00101, 5, 1'b0, "101 ovl");
        loadCfg(8'b101, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, "load 101 novl");
        sendBits(64'b10101, 64'b00100, 5, 1'b0, "101 novl");

        // Idle gap in the middle of a partial match keeps history
        loadCfg(8'b00110, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, "load dflt");
        sendBits(64'b001, 64'b000, 3, 1'b0, "gap head");
        idleCycles(4, 1'b0, "gap idle");
        sendBits(64'b10, 64'b01, 2, 1'b0, "gap tail");

        // Load with a valid bit present: bit dropped, history cleared
        sendBits(64'b0011, 64'b0000, 4, 1'b0, "pre load");
        loadCfg(8'b00110, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, "load discards");
        sendBits(64'b0, 64'b0, 1, 1'b0, "post load");

        // Illegal length zero: an unguarded empty mask would hit on every bit
        loadCfg(8'b00110, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, "load len0");
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, -1, "len0 stream");
        end

        // Illegal length MAX_LEN+1 with an all-zero pattern, stream ending in eight zeros
        loadCfg(8'h00, 4'(MAX_LEN + 1), 1'b1, 1'b0, 1'b0, 1'b1, "load len9");
        for (int i = 0; i < 56; i++) begin
            applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, -1, "len9 stream");
        end
        sendBits(64'h0, 64'h0, 8, 1'b1, "len9 zeros");

        // Reloading a legal length clears the error and restores detection
        loadCfg(8'b00110, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, "reload len5");
        sendBits(64'b00110, 64'b00001, 5, 1'b0, "after reload");

        // Single-bit pattern, overlapping: match every valid cycle, counter saturates at 3
        loadCfg(8'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, "load len1");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, "ones 1");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2, "ones 2");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3, "ones 3");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3, "ones 4");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3, "ones 5");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3, "ones 6");

        // Asynchronous reset between edges while match is high
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        checkValue("async rst match", 32'(match), 32'd0);
        checkValue("async rst cfg_err", 32'(cfg_err), 32'd0);
`ifdef SEQ_DET_CNT_EN
        checkValue("async rst match_cnt", 32'(match_cnt), 32'd0);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = 1'b0;
        rstn     = 1'b1;

        // Reset restored the default pattern rather than the single-bit one
        sendBits(64'b00110, 64'b00001, 5, 1'b0, "post reset dflt");
        idleCycles(1, 1'b0, "tail idle");

        drain = 0;
        while (scoreQ.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #2;
        checkValue("scoreboard drained", 32'(scoreQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
